eth_rx_framer: RTL

Receive-side frame sequencer for the RMII Ethernet path. It takes the nibble stream from the PHY deserializer and strips preamble/SFD. It drives the FCS checker (`cksum`) with exactly the frame body nibbles and stores the frame bytes, minus the FCS, in a circular frame buffer. On the checker's verdict it either commits the frame to a downstream byte stream or rolls the buffer back.

---
 rtl/eth_rx_framer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/eth_rx_framer.sv
// eth_rx_framer: RMII receive framer. It strips the preamble and SFD, feeds the FCS checker,
// buffers each frame without its FCS, and on the verdict commits the frame to the byte stream
// or rolls it back.
// Optional feature macro ETH_RX_RUNT_FILTER_EN: when defined, frames with fewer than 60 stored bytes are dropped.
module eth_rx_framer #(
    parameter int BUF_DEPTH = 2048,
    parameter int LEN_DEPTH = 8,
    parameter int PRE_MIN   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_data,
    input  logic        in_valid,
    output logic [3:0]  ck_data,
    output logic        ck_valid,
    input  logic        ck_done,
    input  logic        ck_kill,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(LEN_DEPTH);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [LW:0] L_ONE = (LW+1)'(1);
    localparam logic [LW:0] L_FULL = (LW+1)'(LEN_DEPTH);
    localparam logic [3:0] P_MIN = 4'(PRE_MIN);
`ifdef ETH_RX_RUNT_FILTER_EN
    localparam logic [10:0] MIN_LEN = 11'd60;
`else
    localparam logic [10:0] MIN_LEN = 11'd1;
`endif

    typedef enum logic [2:0] {IDLE, PRE, BODY, WAIT_CK, SKIP} state_t;
    state_t state;

    logic [3:0] pre_cnt, lo;
    logic nib_odd, ovf;
    logic [2:0] dl_cnt;
    logic [3:0][7:0] dl;
    logic [10:0] len_t;
    logic [PW-1:0] wp_t, wp_c, rp, wp_inc;
    logic [LW:0] lf_wp, lf_rp, lf_cnt;
    logic [10:0] lf_mem [LEN_DEPTH];
    logic [7:0] mem [BUF_DEPTH];
    logic push, spill, ovf_hit, wr_en, verdict, commit;
    logic [10:0] lf_head, cons;
    logic [7:0] rd_q, sk0, sk1;
    logic [1:0] sk_cnt, occ;
    logic rd_pend, rd_en, pop, last;

    assign ck_valid = state == BODY && in_valid;
    assign ck_data  = ck_valid ? in_data : 4'd0;
    assign push     = ck_valid && nib_odd;
    assign spill    = push && dl_cnt == 3'd4;
    assign wp_inc   = wp_t + P_ONE;
    assign ovf_hit  = wp_inc[AW-1:0] == rp[AW-1:0];
    assign wr_en    = spill && !ovf && !ovf_hit;
    assign lf_cnt   = lf_wp - lf_rp;
    assign verdict  = state == WAIT_CK && ck_done;
    assign commit   = verdict && !ck_kill && !nib_odd && len_t >= MIN_LEN && !ovf && lf_cnt != L_FULL;

    assign pop     = m_valid && m_ready;
    assign m_valid = sk_cnt != 2'd0;
    assign m_data  = sk0;
    assign lf_head = lf_mem[lf_rp[LW-1:0]];
    assign last    = cons + 11'd1 == lf_head;
    assign m_last  = m_valid && last;
    assign occ     = sk_cnt + {1'b0, rd_pend};
    assign rd_en   = rp != wp_c && (occ < 2'd2 || (occ == 2'd2 && pop));

    // Receive FSM: preamble hunt, byte assembly through the 4-byte FCS delay line, verdict handling
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pre_cnt    <= 4'd0;
            lo         <= 4'd0;
            nib_odd    <= 1'b0;
            ovf        <= 1'b0;
            dl_cnt     <= 3'd0;
            dl         <= '0;
            len_t      <= 11'd0;
            wp_t       <= '0;
            wp_c       <= '0;
            lf_wp      <= '0;
            frames_ok  <= 16'd0;
            frames_bad <= 16'd0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state   <= in_data == 4'h5 ? PRE : SKIP;
                    pre_cnt <= 4'd1;
                end
                PRE: if (!in_valid) state <= IDLE;
                else if (in_data == 4'h5) pre_cnt <= pre_cnt == 4'hF ? pre_cnt : pre_cnt + 4'd1;
                else if (in_data == 4'hD && pre_cnt >= P_MIN) begin
                    state   <= BODY;
                    nib_odd <= 1'b0;
                    dl_cnt  <= 3'd0;
                    len_t   <= 11'd0;
                    ovf     <= 1'b0;
                end else state <= SKIP;
                BODY: if (!in_valid) state <= WAIT_CK;
                else if (!nib_odd) begin
                    lo      <= in_data;
                    nib_odd <= 1'b1;
                end else begin
                    nib_odd <= 1'b0;
                    dl      <= {dl[2:0], in_data, lo};
                    if (!spill) dl_cnt <= dl_cnt + 3'd1;
                    if (spill && ovf_hit) ovf <= 1'b1;
                    if (wr_en) begin
                        wp_t  <= wp_inc;
                        len_t <= len_t + 11'd1;
                    end
                end
                WAIT_CK: if (ck_done) begin
                    state <= in_valid ? SKIP : IDLE;
                    if (commit) begin
                        wp_c      <= wp_t;
                        lf_wp     <= lf_wp + L_ONE;
                        frames_ok <= frames_ok + {15'd0, frames_ok != 16'hFFFF};
                    end else begin
                        wp_t       <= wp_c;
                        frames_bad <= frames_bad + {15'd0, frames_bad != 16'hFFFF};
                    end
                end
                SKIP: if (!in_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Frame buffer and length FIFO storage; buffer reads are one-cycle synchronous
    always_ff @(posedge clk) begin
        if (wr_en) mem[wp_t[AW-1:0]] <= dl[3];
        if (rd_en) rd_q <= mem[rp[AW-1:0]];
        if (commit) lf_mem[lf_wp[LW-1:0]] <= len_t;
    end

    // Output side: prefetch committed bytes into a 2-entry skid and track frame boundaries
    always_ff @(posedge clk) begin
        if (!rst) begin
            rp      <= '0;
            rd_pend <= 1'b0;
            sk_cnt  <= 2'd0;
            sk0     <= 8'd0;
            sk1     <= 8'd0;
            cons    <= 11'd0;
            lf_rp   <= '0;
        end else begin
            rd_pend <= rd_en;
            if (rd_en) rp <= rp + P_ONE;
            sk_cnt <= sk_cnt + {1'b0, rd_pend} - {1'b0, pop};
            if (pop) begin
                sk0 <= sk_cnt == 2'd2 ? sk1 : rd_q;
                sk1 <= rd_q;
            end else if (rd_pend) begin
                if (sk_cnt == 2'd0) sk0 <= rd_q;
                else sk1 <= rd_q;
            end
            if (pop) begin
                cons <= last ? 11'd0 : cons + 11'd1;
                if (last) lf_rp <= lf_rp + L_ONE;
            end
        end
    end
endmodule
